// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and select constants for the hazard control unit
package hazard_pkg;
    typedef enum logic {RUN, MISS_WAIT} hz_state_t;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W = 2'b01;
    localparam logic [1:0] FWD_M = 2'b10;
endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// fwd_sel: one execute operand's bypass select, memory stage beats writeback, x0 never forwards
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_m,
    input  logic                      valid_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_w,
    input  logic                      valid_w,
    output logic [1:0]                sel
);
    logic hit_m, hit_w;
    // pick the youngest in-flight producer of rs
    always_comb begin
        hit_m = valid_m && reg_write_m && rd_m != '0 && rd_m == rs;
        hit_w = valid_w && reg_write_w && rd_w != '0 && rd_w == rs;
        sel = hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush control for load-use, branch redirect and D-cache miss freeze, plus forwarding
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SRC_WIDTH = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] RS1_d,
    input  logic [REG_ADDR_WIDTH-1:0] RS2_d,
    input  logic [REG_ADDR_WIDTH-1:0] RS1_e,
    input  logic [REG_ADDR_WIDTH-1:0] RS2_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
    input  logic                      RegWrite_e,
    input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
    input  logic                      valid_e,
    input  logic                      PCSrc_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
    input  logic                      RegWrite_m,
    input  logic                      valid_m,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
    input  logic                      RegWrite_w,
    input  logic                      valid_w,
    input  logic                      cache_miss_m,
    input  logic                      cache_ready_m,
    output logic                      en_f,
    output logic                      en_d,
    output logic                      en_e,
    output logic                      en_m,
    output logic                      flush_d_n,
    output logic                      flush_e_n,
    output logic [1:0]                ForwardA_e,
    output logic [1:0]                ForwardB_e,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);
    hz_state_t state, state_nxt;
    logic miss_start, freeze, branch, load_use;
    logic [1:0] fwd_a, fwd_b;

    fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs(RS1_e), .rd_m(Rd_m), .reg_write_m(RegWrite_m), .valid_m(valid_m),
        .rd_w(Rd_w), .reg_write_w(RegWrite_w), .valid_w(valid_w), .sel(fwd_a)
    );

    fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs(RS2_e), .rd_m(Rd_m), .reg_write_m(RegWrite_m), .valid_m(valid_m),
        .rd_w(Rd_w), .reg_write_w(RegWrite_w), .valid_w(valid_w), .sel(fwd_b)
    );

    // miss state register and stall counter that saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!en_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // hazard detection with priority freeze > branch > load-use; reset forces everything inactive
    always_comb begin
        miss_start = state == RUN && cache_miss_m && valid_m && !cache_ready_m;
        freeze = miss_start || (state == MISS_WAIT && !cache_ready_m);
        branch = valid_e && PCSrc_e;
        load_use = valid_e && RegWrite_e && ResultSrc_e == SRC_WIDTH'(RESULT_SRC_LOAD) &&
                   Rd_e != '0 && (Rd_e == RS1_d || Rd_e == RS2_d);
        state_nxt = state == RUN ? (miss_start ? MISS_WAIT : RUN) : (cache_ready_m ? RUN : MISS_WAIT);
        en_f = !rst && !freeze && (branch || !load_use);
        en_d = en_f;
        en_e = !rst && !freeze;
        en_m = en_e;
        flush_d_n = !rst && (freeze || !branch);
        flush_e_n = !rst && (freeze || !(branch || load_use));
        ForwardA_e = rst ? FWD_RF : fwd_a;
        ForwardB_e = rst ? FWD_RF : fwd_b;
    end
endmodule
